munch_gamma_pipe: RTL



---
 rtl/munch_pkg.sv | 27 ++
 rtl/munch_level_scale.sv | 62 ++++++
 rtl/munch_gamma_pipe.sv | 104 ++++++++++
 3 files changed

// File: rtl/munch_pkg.sv
// Shared definitions for the munch gamma pixel pipe: curve encodings and a bit-reverse helper.
// Pure declarations; no latency, no flow control.
package munch_pkg;

    localparam logic [1:0] MODE_LIN  = 2'd0;
    localparam logic [1:0] MODE_SQR  = 2'd1;
    localparam logic [1:0] MODE_CUBE = 2'd2;
    localparam logic [1:0] MODE_INV  = 2'd3;

    localparam int BITREV_MAX_W = 32;

    // Reverses the low w bits of v; bits at and above w come back as zero.
    function automatic logic [BITREV_MAX_W-1:0] bit_rev(input logic [BITREV_MAX_W-1:0] v,
                                                        input int w);
        logic [BITREV_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < BITREV_MAX_W; i++) begin
            for (int j = 0; j < BITREV_MAX_W; j++) begin
                if ((i < w) && (j == w - 1 - i)) begin
                    r[i] = v[j];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/munch_level_scale.sv
// Per-channel transfer curve and PWM compare: square, cube, select, then level > cmp.
// Latency 2 cycles from the stage-1 registers; no backpressure, o_lit holds unless i_load.
module munch_level_scale
    import munch_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [DEPTH-1:0] i_level,
    input  logic [DEPTH-1:0] i_cmp,
    input  logic [1:0]       i_mode,
    input  logic             i_load,
    output logic             o_lit
);

    logic [2*DEPTH-1:0] w_sq_prod;
    logic [2*DEPTH-1:0] w_cube_prod;
    logic [DEPTH-1:0]   w_cube;
    logic [DEPTH-1:0]   w_sel;

    logic [DEPTH-1:0]   r_level2;
    logic [DEPTH-1:0]   r_sq2;
    logic [DEPTH-1:0]   r_cmp2;
    logic [1:0]         r_mode2;
    logic               r_lit;

    assign w_sq_prod = {{DEPTH{1'b0}}, i_level} * {{DEPTH{1'b0}}, i_level};

    always_ff @(posedge clk) begin
        r_level2 <= i_level;
        r_sq2    <= w_sq_prod[2*DEPTH-1:DEPTH];
        r_cmp2   <= i_cmp;
        r_mode2  <= i_mode;
    end

    assign w_cube_prod = {{DEPTH{1'b0}}, r_sq2} * {{DEPTH{1'b0}}, r_level2};
    assign w_cube      = w_cube_prod[2*DEPTH-1:DEPTH];

    always_comb begin
        w_sel = r_level2;
        case (r_mode2)
            MODE_LIN:  w_sel = r_level2;
            MODE_SQR:  w_sel = r_sq2;
            MODE_CUBE: w_sel = w_cube;
            MODE_INV:  w_sel = ~r_level2;
            default:   w_sel = r_level2;
        endcase
    end

    // i_load is the stage-2 valid, so idle cycles leave the last PWM bit in place.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_lit <= 1'b0;
        end else if (i_load) begin
            r_lit <= (w_sel > r_cmp2);
        end
    end

    assign o_lit = r_lit;

endmodule

// File: rtl/munch_gamma_pipe.sv
// Munch XOR pattern -> per-channel gamma-curved level -> PWM rgb bits for the panel shifter.
// Latency exactly 3 cycles; no backpressure, stages advance every cycle.
module munch_gamma_pipe
    import munch_pkg::*;
#(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned CHANNELS    = 3,
    parameter int unsigned XY_W        = 6,
    parameter int unsigned FRAME_W     = 13,
    parameter int unsigned SPEED_SHIFT = 2,
    parameter int unsigned CH_OFFSET   = 21,
    parameter logic [1:0]  RESET_MODE  = 2'd0
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                in_valid,
    input  logic [FRAME_W-1:0]  frame,
    input  logic [DEPTH-1:0]    subframe,
    input  logic [XY_W-1:0]     x,
    input  logic [XY_W-1:0]     y,
    input  logic [1:0]          mode_req,
    output logic                out_valid,
    output logic [CHANNELS-1:0] rgb,
    output logic [1:0]          mode_active
);

    logic [XY_W-1:0]     w_z;
    logic                w_latch;
    logic [1:0]          w_mode;
    logic [DEPTH-1:0]    w_cmp;
    logic [CHANNELS-1:0] w_lit;

    logic [1:0]          r_mode_active;
    logic                r_vld1;
    logic                r_vld2;
    logic                r_vld3;
    logic [DEPTH-1:0]    r_cmp1;
    logic [1:0]          r_mode1;

    assign w_z     = x ^ y ^ frame[SPEED_SHIFT +: XY_W];
    assign w_latch = in_valid && (x == '0) && (y == '0) && (subframe == '0);
    // The latching pixel itself already renders with the requested curve.
    assign w_mode  = w_latch ? mode_req : r_mode_active;
    assign w_cmp   = DEPTH'(bit_rev(BITREV_MAX_W'(subframe), int'(DEPTH)));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_mode_active <= RESET_MODE;
            r_vld1        <= 1'b0;
            r_vld2        <= 1'b0;
            r_vld3        <= 1'b0;
        end else begin
            if (w_latch) begin
                r_mode_active <= mode_req;
            end
            r_vld1 <= in_valid;
            r_vld2 <= r_vld1;
            r_vld3 <= r_vld2;
        end
    end

    always_ff @(posedge clk) begin
        r_cmp1  <= w_cmp;
        r_mode1 <= w_mode;
    end

    for (genvar c = 0; c < int'(CHANNELS); c++) begin : g_ch
        localparam int unsigned OFF_RAW = (c * CH_OFFSET) % (1 << XY_W);
        localparam logic [XY_W-1:0] OFF = XY_W'(OFF_RAW);

        logic [XY_W-1:0]  w_zc;
        logic [DEPTH-1:0] w_lvl;
        logic [DEPTH-1:0] r_lvl1;

        assign w_zc = w_z + OFF;

        if (XY_W >= DEPTH) begin : g_trunc
            assign w_lvl = w_zc[XY_W-1 -: DEPTH];
        end else begin : g_pad
            assign w_lvl = {w_zc, {(DEPTH-XY_W){1'b0}}};
        end

        always_ff @(posedge clk) begin
            r_lvl1 <= w_lvl;
        end

        munch_level_scale #(
            .DEPTH (DEPTH)
        ) u_scale (
            .clk     (clk),
            .resetn  (resetn),
            .i_level (r_lvl1),
            .i_cmp   (r_cmp1),
            .i_mode  (r_mode1),
            .i_load  (r_vld2),
            .o_lit   (w_lit[c])
        );
    end

    assign out_valid   = r_vld3;
    assign rgb         = w_lit;
    assign mode_active = r_mode_active;

endmodule
